ldpc_lmem_layered: RTL
======================

# ldpc_lmem_layered

Parametrised, multi-layer L-message memory for the layered LDPC decoder. It stores P rows × NB circulant blocks × WT weight × W-bit messages per word, with a separate depth-DEPTH bank for each of LAYERS layers. On read it applies a programmable row rotation so that data written in one layer's pattern can be read out in the next layer's pattern. A feedback mode writes the previous read result back into the array, so messages can be held across iterations without a round trip through the processing units.

## Interface
Parameters:
- W, 6: message width in bits
- P, 26: rows per cycle
- NB, 16: circulant blocks per layer
- WT, 2: circulant weight
- DEPTH, 20: words per layer (ceil(Z/P))
- ADDRW, 5: address width, ≥ clog2(DEPTH)
- LAYERS, 2: layer banks
- LW, max(1,clog2(LAYERS)): layer-select width
- SW, max(1,clog2(P)): rotation-amount width
- DW, P*NB*WT*W: data word width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_en_regin  in  1  read request
- rd_layer_regin  in  LW  read layer
- rd_address_regin  in  ADDRW  read address
- rd_shift_regin  in  SW  read rotation, in rows
- wr_en_regin  in  1  write request
- wr_layer_regin  in  LW  write layer
- wr_address_regin  in  ADDRW  write address
- wr_data_regin  in  DW  write data; row j occupies bits [(j+1)*NB*WT*W-1 : j*NB*WT*W]
- feedback_en_regin  in  1  1: write source is rd_data_regout instead of wr_data_regin
- rd_data_regout  out  DW  rotated read data
- rd_valid_regout  out  1  rd_data_regout carries a new read result
- err_regout  out  1  sticky error flag

## Operation
- Stage 0 (input register): every *_regin signal is registered on each clk edge. On rst these registers clear to 0.
- Storage: LAYERS*DEPTH words of DW bits, indexed by {layer, address}. The array is not cleared by rst.
- Write: a registered wr_en writes to {wr_layer, wr_address}. The data written is the registered wr_data when registered feedback_en=0. When it is 1, the data written is the value present on rd_data_regout in that same cycle.
- Read: a registered rd_en latches the array word at {rd_layer, rd_address} into an internal read register (stage 1). Stage 2 rotates that word by the registered shift s and loads rd_data_regout.
- Rotation: output row j = stored row (j+s) mod P. With s=0 the word passes through unchanged.
- Read/write collision: if stage 0 holds a read and a write to the same {layer, address} in the same cycle, the read returns the newly written data (write-first).
- Range errors: address ≥ DEPTH, layer ≥ LAYERS, or s ≥ P sets err_regout to 1. The flag stays set until rst.
  - A write with an invalid address or layer is dropped.
  - A read with an invalid address or layer returns all-zero data, with rd_valid still asserted.
  - A read with s ≥ P uses s=0.
- While rd_en is idle, rd_data_regout holds its last value and rd_valid_regout is 0.

## Timing
- Read latency is 3 edges. If rd_en_regin is sampled at edge t, then rd_valid_regout=1 and rd_data_regout is valid after edge t+3. rd_valid_regout is a one-cycle pulse per request.
- Write latency is 2 edges. A write sampled at edge t updates the array at edge t+1. A read sampled at edge t+1 or later sees the new data. A same-address read sampled at edge t sees it through the write-first bypass.
- Full throughput: one read and one write can be accepted every cycle, with no stalls.
- Feedback: a write issued 3 cycles after a read stores that read's rotated result.
- Reset values after any rst edge:
  - rd_data_regout = 0
  - rd_valid_regout = 0
  - err_regout = 0
  - all pipeline valids = 0
- rst asserted mid-operation squashes every in-flight read and write. Nothing is written on or after the reset edge.

## Test plan
- Write layer0 addr0..19 with word k = pattern(k), then read them back with s=0. Required: data matches after exactly 3 cycles, and rd_valid_regout pulses 20 times.
- Write row j = j in layer1 addr 5, then read with s=3. Required: output row 0 = 3, row 22 = 25, row 23 = 0, row 25 = 2.
- In the same cycle, read and write layer0 addr 7 with 0xA…A (old content 0x5…5). Required: the read returns 0xA…A.
- Read addr 2 (content X), then set feedback_en=1 and write addr 9 three cycles later, then read addr 9. Required: the final read returns rotate(X, s of the first read).
- Write addr 25 (DEPTH=20), then read addr 25. Required: err_regout=1 from that point, the write is dropped, and the read returns 0 with valid=1.
- Assert rst while two reads are in flight. Required: no rd_valid pulse, rd_data_regout=0, err_regout=0.

Source files
------------

// File: rtl/ldpc_lmem_layered.sv
// ============================================================================
// ldpc_lmem_layered : banked L-message store with row-rotating read and feedback write
// Revision 1.0
// ============================================================================
`default_nettype none

module ldpc_lmem_layered #(
  parameter int W      = 6,
  parameter int P      = 26,
  parameter int NB     = 16,
  parameter int WT     = 2,
  parameter int DEPTH  = 20,
  parameter int ADDRW  = 5,
  parameter int LAYERS = 2,
  parameter int LW     = (LAYERS > 1) ? $clog2(LAYERS) : 1,
  parameter int SW     = (P > 1) ? $clog2(P) : 1,
  localparam int DW    = P * NB * WT * W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_regin,
  input  logic [LW-1:0]     rd_layer_regin,
  input  logic [ADDRW-1:0]  rd_address_regin,
  input  logic [SW-1:0]     rd_shift_regin,
  input  logic              wr_en_regin,
  input  logic [LW-1:0]     wr_layer_regin,
  input  logic [ADDRW-1:0]  wr_address_regin,
  input  logic [DW-1:0]     wr_data_regin,
  input  logic              feedback_en_regin,
  output logic [DW-1:0]     rd_data_regout,
  output logic              rd_valid_regout,
  output logic              err_regout
);

  localparam int               RW        = NB * WT * W;
  localparam logic [ADDRW:0]   C_DEPTH   = (ADDRW + 1)'(DEPTH);
  localparam logic [LW:0]      C_LAYERS  = (LW + 1)'(LAYERS);
  localparam logic [SW:0]      C_P       = (SW + 1)'(P);

  logic              r_rd_en;
  logic [LW-1:0]     r_rd_layer;
  logic [ADDRW-1:0]  r_rd_addr;
  logic [SW-1:0]     r_rd_shift;
  logic              r_wr_en;
  logic [LW-1:0]     r_wr_layer;
  logic [ADDRW-1:0]  r_wr_addr;
  logic [DW-1:0]     r_wr_data;
  logic              r_fb_en;

  logic              r_s1_vld;
  logic [DW-1:0]     r_s1_word;
  logic [SW-1:0]     r_s1_shift;
  logic              r_s2_vld;
  logic [DW-1:0]     r_s2_word;

  logic [DW-1:0]     r_mem [LAYERS][DEPTH];

  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_sh_ok;
  logic              w_wr_go;
  logic              w_hit;
  logic              w_err_evt;
  logic [DW-1:0]     w_wr_data;
  logic [DW-1:0]     w_rot;

  assign w_rd_ok   = ({1'b0, r_rd_addr} < C_DEPTH) && ({1'b0, r_rd_layer} < C_LAYERS);
  assign w_wr_ok   = ({1'b0, r_wr_addr} < C_DEPTH) && ({1'b0, r_wr_layer} < C_LAYERS);
  assign w_sh_ok   = ({1'b0, r_rd_shift} < C_P);
  assign w_wr_go   = r_wr_en && w_wr_ok;
  // Feedback takes whatever the output register shows this cycle.
  assign w_wr_data = r_fb_en ? rd_data_regout : r_wr_data;
  assign w_hit     = w_wr_go && r_rd_en && w_rd_ok &&
                     (r_rd_layer == r_wr_layer) && (r_rd_addr == r_wr_addr);
  assign w_err_evt = (r_rd_en && !(w_rd_ok && w_sh_ok)) || (r_wr_en && !w_wr_ok);

  // Output row j takes stored row (j+s) mod P; s is already clamped below P.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < P; j++) begin
      int k;
      k = j + int'(r_s1_shift);
      if (k >= P) k = k - P;
      w_rot[j*RW +: RW] = r_s1_word[k*RW +: RW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_go) begin
      r_mem[r_wr_layer][r_wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_en         <= 1'b0;
      r_rd_layer      <= '0;
      r_rd_addr       <= '0;
      r_rd_shift      <= '0;
      r_wr_en         <= 1'b0;
      r_wr_layer      <= '0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_fb_en         <= 1'b0;
      r_s1_vld        <= 1'b0;
      r_s1_word       <= '0;
      r_s1_shift      <= '0;
      r_s2_vld        <= 1'b0;
      r_s2_word       <= '0;
      rd_data_regout  <= '0;
      rd_valid_regout <= 1'b0;
      err_regout      <= 1'b0;
    end else begin
      r_rd_en    <= rd_en_regin;
      r_rd_layer <= rd_layer_regin;
      r_rd_addr  <= rd_address_regin;
      r_rd_shift <= rd_shift_regin;
      r_wr_en    <= wr_en_regin;
      r_wr_layer <= wr_layer_regin;
      r_wr_addr  <= wr_address_regin;
      r_wr_data  <= wr_data_regin;
      r_fb_en    <= feedback_en_regin;

      r_s1_vld <= r_rd_en;
      if (r_rd_en) begin
        r_s1_shift <= w_sh_ok ? r_rd_shift : '0;
        if (w_hit) begin
          r_s1_word <= w_wr_data;
        end else if (w_rd_ok) begin
          r_s1_word <= r_mem[r_rd_layer][r_rd_addr];
        end else begin
          r_s1_word <= '0;
        end
      end

      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_word <= w_rot;
      end

      rd_valid_regout <= r_s2_vld;
      if (r_s2_vld) begin
        rd_data_regout <= r_s2_word;
      end

      if (w_err_evt) begin
        err_regout <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
